// File: rtl/seq_lock_if.sv
// Key/button and status bundle for the sequence-lock controller.
// The slave side is the lock controller; the master side is whatever
// drives the debounced keys and watches the door/status lines.
interface seq_lock_if #(
  parameter int KEY_W     = 2,
  parameter int MAX_TRIES = 3
);
  localparam int TRY_W = $clog2(MAX_TRIES + 1);

  logic [KEY_W-1:0] key;
  logic             enter;
  logic             prog;
  logic             open;
  logic             erro;
  logic             locked;
  logic             prog_mode;
  logic [TRY_W-1:0] tries_left;

  modport master (
    output key, enter, prog,
    input  open, erro, locked, prog_mode, tries_left
  );

  modport slave (
    input  key, enter, prog,
    output open, erro, locked, prog_mode, tries_left
  );
endinterface

// File: rtl/seq_lock_param.sv
// Parametrised sequence-lock controller.
// Collects SEQ_LEN digits on enter presses, opens on a full match, reports a
// wrong code only after the last digit, locks out after MAX_TRIES failures,
// and allows the code to be rewritten while the door is open.
module seq_lock_param #(
  parameter int KEY_W     = 2,
  parameter int SEQ_LEN   = 3,
  parameter int MAX_TRIES = 3,
  parameter int OPEN_CYC  = 4,
  parameter int LOCK_CYC  = 16,
  parameter logic [SEQ_LEN*KEY_W-1:0] DEFAULT_CODE = {2'b10, 2'b11, 2'b01}
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_lock_if.slave    bus
);

  localparam int IDX_W   = $clog2(SEQ_LEN);
  localparam int TRY_W   = $clog2(MAX_TRIES + 1);
  localparam int TMR_MAX = (OPEN_CYC > LOCK_CYC) ? OPEN_CYC : LOCK_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(SEQ_LEN - 1);
  localparam logic [TRY_W-1:0] TRY_LAST  = TRY_W'(MAX_TRIES - 1);
  localparam logic [TRY_W-1:0] TRY_FULL  = TRY_W'(MAX_TRIES);
  localparam logic [TMR_W-1:0] OPEN_LOAD = TMR_W'(OPEN_CYC - 1);
  localparam logic [TMR_W-1:0] LOCK_LOAD = TMR_W'(LOCK_CYC - 1);

  typedef enum logic [2:0] {
    ENTRY = 3'd0,
    OPEN  = 3'd1,
    PROG  = 3'd2,
    ERR   = 3'd3,
    LOCK  = 3'd4
  } state_t;

  state_t                     state_q, state_d;
  logic                       enter_q;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic                       mismatch_q, mismatch_d;
  logic [TRY_W-1:0]           tries_q, tries_d;
  logic [SEQ_LEN*KEY_W-1:0]   code_q, code_d;
  logic [TMR_W-1:0]           timer_q, timer_d;
  logic                       press;
  logic                       digit_miss;
  logic                       seq_miss;

  // A press is the rising edge of the debounced enter level.
  assign press = bus.enter & ~enter_q;

  // enter history runs in every state so a held button never re-triggers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) enter_q <= 1'b0;
    else        enter_q <= bus.enter;
  end

  // Control and code registers; the programmed code is lost on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ENTRY;
      idx_q      <= '0;
      mismatch_q <= 1'b0;
      tries_q    <= '0;
      code_q     <= DEFAULT_CODE;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      mismatch_q <= mismatch_d;
      tries_q    <= tries_d;
      code_q     <= code_d;
      timer_q    <= timer_d;
    end
  end

  // Next-state, digit compare/store, attempt counting and timers.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    mismatch_d = mismatch_q;
    tries_d    = tries_q;
    code_d     = code_q;
    timer_d    = timer_q;
    digit_miss = (bus.key != code_q[int'(idx_q)*KEY_W +: KEY_W]);
    seq_miss   = mismatch_q | digit_miss;

    case (state_q)
      ENTRY: begin
        if (press) begin
          if (idx_q == IDX_LAST) begin
            // Verdict uses the accumulated mismatch including this last digit.
            idx_d      = '0;
            mismatch_d = 1'b0;
            if (!seq_miss) begin
              state_d = OPEN;
              tries_d = '0;
              timer_d = OPEN_LOAD;
            end else if (tries_q == TRY_LAST) begin
              state_d = LOCK;
              tries_d = TRY_FULL;
              timer_d = LOCK_LOAD;
            end else begin
              state_d = ERR;
              tries_d = tries_q + TRY_W'(1);
            end
          end else begin
            idx_d      = idx_q + IDX_W'(1);
            mismatch_d = seq_miss;
          end
        end
      end

      OPEN: begin
        // A program request beats the open timer running out.
        if (bus.prog) begin
          state_d = PROG;
          idx_d   = '0;
        end else if (timer_q == '0) begin
          state_d = ENTRY;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end

      PROG: begin
        if (press) begin
          code_d[int'(idx_q)*KEY_W +: KEY_W] = bus.key;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = ENTRY;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      ERR: begin
        state_d = ENTRY;
      end

      LOCK: begin
        if (timer_q == '0) begin
          state_d = ENTRY;
          tries_d = '0;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end

      default: begin
        state_d = ENTRY;
      end
    endcase
  end

  // Moore outputs decoded from the registered state.
  assign bus.open       = (state_q == OPEN);
  assign bus.erro       = (state_q == ERR);
  assign bus.locked     = (state_q == LOCK);
  assign bus.prog_mode  = (state_q == PROG);
  assign bus.tries_left = TRY_FULL - tries_q;

endmodule
